// File: rtl/spi_slave.sv
// SPI slave with selectable mode (0-3): oversamples SCK/CS/MOSI in the i_Clk domain,
// shifts bytes MSb first in both directions and double-buffers the transmit byte.
module spi_slave #(
    parameter int SPI_MODE = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_CS_Active,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En
);

    localparam logic       CPOL      = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic       CPHA      = (SPI_MODE == 1) || (SPI_MODE == 3);
    localparam logic [2:0] SYNC_IDLE = {1'b0, 1'b1, CPOL};

    logic [2:0] sync_in;
    logic [2:0] sync_out;
    logic       sck_s;
    logic       cs_n_s;
    logic       mosi_s;

    assign sync_in = {i_SPI_MOSI, i_SPI_CS_n, i_SPI_Clk};

    // Equal-depth synchronizers keep MOSI aligned with the SCK edge that samples it.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic [1:0] ff_reg;
            always_ff @(posedge i_Clk) begin
                if (i_Rst) begin
                    ff_reg <= {2{SYNC_IDLE[gi]}};
                end else begin
                    ff_reg <= {ff_reg[0], sync_in[gi]};
                end
            end
            assign sync_out[gi] = ff_reg[1];
        end
    endgenerate

    assign sck_s  = sync_out[0];
    assign cs_n_s = sync_out[1];
    assign mosi_s = sync_out[2];

    logic       sck_prev_reg;
    logic [1:0] settle_reg;
    logic       armed_reg;
    logic       frame_active_reg;
    logic [2:0] bit_cnt_reg;
    logic [6:0] rx_shift_reg;
    logic [7:0] rx_byte_reg;
    logic       rx_dv_reg;
    logic [7:0] tx_hold_reg;
    logic       tx_hold_full_reg;
    logic [7:0] tx_shift_reg;
    logic [2:0] tx_idx_reg;
    logic [2:0] tx_idx_next;
    logic       miso_reg;
    logic       boundary_pending_reg;

    logic       in_frame;
    logic       frame_start;
    logic       sck_rise;
    logic       sck_fall;
    logic       lead_edge;
    logic       trail_edge;
    logic       sample_edge;
    logic       shift_edge;
    logic       boundary;
    logic [7:0] next_byte;

    // A frame only starts from CS seen high once the synchronizers hold real input
    // after reset, so CS held low through reset is not mistaken for a new frame.
    assign in_frame    = frame_active_reg & ~cs_n_s;
    assign frame_start = armed_reg & ~frame_active_reg & ~cs_n_s;
    assign sck_rise    = in_frame & sck_s & ~sck_prev_reg;
    assign sck_fall    = in_frame & ~sck_s & sck_prev_reg;
    assign lead_edge   = CPOL ? sck_fall : sck_rise;
    assign trail_edge  = CPOL ? sck_rise : sck_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign boundary    = frame_start | (boundary_pending_reg & in_frame);
    assign next_byte   = tx_hold_full_reg ? tx_hold_reg : 8'hFF;
    assign tx_idx_next = tx_idx_reg - 3'd1;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sck_prev_reg     <= CPOL;
            settle_reg       <= 2'b00;
            armed_reg        <= 1'b0;
            frame_active_reg <= 1'b0;
        end else begin
            sck_prev_reg <= sck_s;
            settle_reg   <= {settle_reg[0], 1'b1};
            if (settle_reg[1] && cs_n_s) begin
                armed_reg <= 1'b1;
            end
            if (cs_n_s) begin
                frame_active_reg <= 1'b0;
            end else if (frame_start) begin
                frame_active_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            bit_cnt_reg  <= 3'd7;
            rx_shift_reg <= 7'd0;
            rx_byte_reg  <= 8'h00;
            rx_dv_reg    <= 1'b0;
        end else begin
            rx_dv_reg <= 1'b0;
            if (!in_frame) begin
                bit_cnt_reg  <= 3'd7;
                rx_shift_reg <= 7'd0;
            end else if (sample_edge) begin
                bit_cnt_reg <= bit_cnt_reg - 3'd1;
                if (bit_cnt_reg == 3'd0) begin
                    rx_byte_reg <= {rx_shift_reg, mosi_s};
                    rx_dv_reg   <= 1'b1;
                end else begin
                    rx_shift_reg <= {rx_shift_reg[5:0], mosi_s};
                end
            end
        end
    end

    // A boundary frees the holding register before a same-cycle write lands in it.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            tx_hold_reg      <= 8'h00;
            tx_hold_full_reg <= 1'b0;
        end else begin
            if (boundary) begin
                tx_hold_full_reg <= 1'b0;
            end
            if (i_TX_DV && (!tx_hold_full_reg || boundary)) begin
                tx_hold_reg      <= i_TX_Byte;
                tx_hold_full_reg <= 1'b1;
            end
        end
    end

    // tx_idx_reg is the bit index on MISO; each output edge steps it down and wraps
    // 0 -> 7, so the byte reloaded after bit 0 goes out from its bit 7 next.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            tx_shift_reg         <= 8'h00;
            tx_idx_reg           <= 3'd0;
            miso_reg             <= 1'b0;
            boundary_pending_reg <= 1'b0;
        end else begin
            boundary_pending_reg <= 1'b0;
            if (frame_start) begin
                tx_shift_reg <= next_byte;
                tx_idx_reg   <= CPHA ? 3'd0 : 3'd7;
                miso_reg     <= CPHA ? 1'b0 : next_byte[7];
            end else if (!in_frame) begin
                tx_shift_reg <= 8'h00;
                tx_idx_reg   <= 3'd0;
                miso_reg     <= 1'b0;
            end else begin
                if (boundary_pending_reg) begin
                    tx_shift_reg <= next_byte;
                end
                if (shift_edge) begin
                    miso_reg             <= tx_shift_reg[tx_idx_next];
                    tx_idx_reg           <= tx_idx_next;
                    boundary_pending_reg <= (tx_idx_next == 3'd0);
                end
            end
        end
    end

    assign o_TX_Ready    = ~tx_hold_full_reg;
    assign o_RX_DV       = rx_dv_reg;
    assign o_RX_Byte     = rx_byte_reg;
    assign o_CS_Active   = frame_active_reg;
    assign o_SPI_MISO    = miso_reg;
    assign o_SPI_MISO_En = frame_active_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode driven by a behavioural master;
// received bytes are checked by a queue-based scoreboard monitor.
module tb_spi_slave;

    localparam int H = 6;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] sck;
    logic [3:0] cs_n;
    logic [3:0] mosi;
    logic [3:0] miso;
    logic [3:0] miso_en;
    logic [3:0] tx_dv;
    logic [3:0] tx_ready;
    logic [3:0] rx_dv;
    logic [3:0] cs_active;
    logic [7:0] tx_byte [4];
    logic [7:0] rx_byte [4];

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            spi_slave #(.SPI_MODE(gi)) dut (
                .i_Clk        (clk),
                .i_Rst        (rst),
                .i_TX_Byte    (tx_byte[gi]),
                .i_TX_DV      (tx_dv[gi]),
                .o_TX_Ready   (tx_ready[gi]),
                .o_RX_DV      (rx_dv[gi]),
                .o_RX_Byte    (rx_byte[gi]),
                .o_CS_Active  (cs_active[gi]),
                .i_SPI_Clk    (sck[gi]),
                .i_SPI_CS_n   (cs_n[gi]),
                .i_SPI_MOSI   (mosi[gi]),
                .o_SPI_MISO   (miso[gi]),
                .o_SPI_MISO_En(miso_en[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: every o_RX_DV cycle must match the oldest expected byte.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int m = 0; m < 4; m++) begin
                if (rx_dv[m]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rx_unexpected mode=%0d actual=%h required=none", m, rx_byte[m]);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_mode", m, int'(e.mode));
                        check("rx_byte", int'(rx_byte[m]), int'(e.data));
                    end
                end
            end
        end
    end

    task automatic tx_load(input int m, input logic [7:0] b);
        @(negedge clk);
        tx_byte[m] = b;
        tx_dv[m]   = 1'b1;
        @(negedge clk);
        tx_dv[m]   = 1'b0;
    endtask

    task automatic cs_begin(input int m);
        cs_n[m] = 1'b0;
        wait_clk(2 * H);
    endtask

    task automatic cs_end(input int m);
        wait_clk(H);
        cs_n[m] = 1'b1;
        wait_clk(2 * H);
    endtask

    task automatic spi_xfer(input int m, input logic [7:0] b, input int nbits, output logic [7:0] rd);
        logic cpol;
        logic cpha;
        cpol = (m >= 2);
        cpha = (m == 1) || (m == 3);
        rd   = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                mosi[m] = b[i];
                wait_clk(H);
                rd = {rd[6:0], miso[m]};
                sck[m] = ~cpol;
                wait_clk(H);
                sck[m] = cpol;
            end else begin
                sck[m]  = ~cpol;
                mosi[m] = b[i];
                wait_clk(H);
                rd = {rd[6:0], miso[m]};
                sck[m] = cpol;
                wait_clk(H);
            end
        end
    endtask

    task automatic do_byte(input int m, input logic [7:0] send, input logic [7:0] exp_read);
        logic [7:0] rd;
        exp_t e;
        e.mode = 2'(m);
        e.data = send;
        exp_q.push_back(e);
        spi_xfer(m, send, 8, rd);
        $display("xfer mode=%0d mosi=%h miso=%h", m, send, rd);
        check("miso_read", int'(rd), int'(exp_read));
    endtask

    task automatic reset_check(input int m);
        check("rst_tx_ready", int'(tx_ready[m]), 1);
        check("rst_rx_dv", int'(rx_dv[m]), 0);
        check("rst_rx_byte", int'(rx_byte[m]), 0);
        check("rst_cs_active", int'(cs_active[m]), 0);
        check("rst_miso", int'(miso[m]), 0);
        check("rst_miso_en", int'(miso_en[m]), 0);
    endtask

    initial begin
        logic [7:0] rd;
        sck   = 4'b1100;
        cs_n  = 4'hF;
        mosi  = 4'h0;
        tx_dv = 4'h0;
        for (int m = 0; m < 4; m++) tx_byte[m] = 8'h00;
        rst = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(5);
        for (int m = 0; m < 4; m++) reset_check(m);

        // Mode 0 basic exchange; a second write while full is ignored
        tx_load(0, 8'hA5);
        check("tx_ready_drop", int'(tx_ready[0]), 0);
        tx_load(0, 8'h5A);
        check("tx_ready_full", int'(tx_ready[0]), 0);
        cs_begin(0);
        check("cs_active", int'(cs_active[0]), 1);
        check("miso_en", int'(miso_en[0]), 1);
        do_byte(0, 8'h3C, 8'hA5);
        cs_end(0);
        check("cs_idle", int'(cs_active[0]), 0);
        check("tx_ready_after", int'(tx_ready[0]), 1);

        // Modes 1-3
        for (int m = 1; m < 4; m++) begin
            tx_load(m, 8'h81);
            cs_begin(m);
            do_byte(m, 8'h7E, 8'h81);
            cs_end(m);
        end

        // Back-to-back bytes in one frame, second byte loaded after the first boundary
        for (int m = 0; m < 4; m++) begin
            tx_load(m, 8'h11);
            cs_begin(m);
            check("b2b_ready_boundary", int'(tx_ready[m]), 1);
            tx_load(m, 8'h22);
            do_byte(m, 8'hC3, 8'h11);
            do_byte(m, 8'h5A, 8'h22);
            cs_end(m);
            check("b2b_ready_end", int'(tx_ready[m]), 1);
        end

        // Underrun: nothing loaded, master reads FF
        for (int m = 0; m < 4; m++) begin
            cs_begin(m);
            do_byte(m, 8'h99, 8'hFF);
            cs_end(m);
            check("underrun_ready", int'(tx_ready[m]), 1);
        end

        // Partial byte: CS released after 5 SCK cycles; holding register survives
        tx_load(0, 8'h0F);
        cs_begin(0);
        tx_load(0, 8'h96);
        check("partial_hold_full", int'(tx_ready[0]), 0);
        spi_xfer(0, 8'hAA, 5, rd);
        $display("xfer mode=0 partial mosi=aa bits=5");
        cs_end(0);
        check("partial_ready", int'(tx_ready[0]), 0);
        check("partial_miso", int'(miso[0]), 0);
        check("partial_miso_en", int'(miso_en[0]), 0);
        cs_begin(0);
        do_byte(0, 8'h55, 8'h96);
        cs_end(0);

        // Reset mid-byte with CS still low: no RX, no response until a fresh CS edge
        cs_begin(0);
        tx_load(0, 8'h3C);
        spi_xfer(0, 8'hF0, 4, rd);
        $display("xfer mode=0 partial mosi=f0 bits=4 then reset");
        @(negedge clk);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
        reset_check(0);
        wait_clk(10);
        check("no_resume_cs", int'(cs_active[0]), 0);
        check("no_resume_en", int'(miso_en[0]), 0);
        cs_end(0);
        tx_load(0, 8'h24);
        cs_begin(0);
        do_byte(0, 8'hE7, 8'h24);
        cs_end(0);

        wait_clk(20);
        check("rx_pending", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SPI_MODE, default 0, meaning SPI mode 0-3: CPOL = mode 2 or 3; CPHA = mode 1 or 3.
REQ-002 i_Clk  input  1  system clock; single clock domain for all logic.
REQ-003 i_Rst  input  1  reset, synchronous and active-high.
REQ-004 i_TX_Byte  input  8  next byte to shift out on MISO.
REQ-005 i_TX_DV  input  1  one-cycle pulse; i_TX_Byte valid.
REQ-006 o_TX_Ready  output  1  transmit holding register empty; i_TX_DV is accepted.
REQ-007 o_RX_DV  output  1  one-cycle pulse; o_RX_Byte holds a completed byte.
REQ-008 o_RX_Byte  output  8  last completed received byte, MSb first.
REQ-009 o_CS_Active  output  1  synchronized chip-select asserted.
REQ-010 i_SPI_Clk  input  1  SCK from the master, asynchronous to i_Clk.
REQ-011 i_SPI_CS_n  input  1  chip select, active-low, asynchronous.
REQ-012 i_SPI_MOSI  input  1  serial data in, asynchronous.
REQ-013 o_SPI_MISO  output  1  serial data out.
REQ-014 o_SPI_MISO_En  output  1  MISO output enable; tri-stating is done at top level.

Function
REQ-015 i_SPI_Clk, i_SPI_CS_n and i_SPI_MOSI SHALL each pass through a 2-flop synchronizer with equal depth, so MOSI stays aligned to SCK.
REQ-016 Edge detection SHALL compare the synchronized SCK against its previous registered value, and SHALL be qualified by synchronized CS being low.
REQ-017 Leading edge SHALL be rising for CPOL=0 and falling for CPOL=1; trailing edge is the opposite transition.
REQ-018 Sampling: CPHA=0 SHALL sample MOSI on the leading edge; CPHA=1 SHALL sample on the trailing edge. Bits SHALL be shifted in MSb first.
REQ-019 Shifting out: CPHA=0 SHALL change MISO on the trailing edge; CPHA=1 SHALL change MISO on the leading edge.
REQ-020 Bit counter SHALL be 3 bits, reset to 7, decrement per sample edge, and wrap 0 -> 7 for back-to-back bytes with no CS deassertion.
REQ-021 On the sample edge where the bit count is 0, o_RX_Byte SHALL update and o_RX_DV SHALL pulse for exactly 1 cycle, in the next i_Clk cycle.
REQ-022 TX holding register:
- i_TX_DV while o_TX_Ready=1 SHALL load it and drop o_TX_Ready on the next cycle.
- i_TX_DV while o_TX_Ready=0 SHALL be ignored.
REQ-023 Byte boundary (CS assertion, or the cycle after the bit-0 output edge) SHALL move the holding register into the shift register and reassert o_TX_Ready.
- If the holding register is empty (underrun), the shift register SHALL load 8'hFF.
REQ-024 CPHA=0: on the synchronized CS falling edge, MISO SHALL present shift-register bit 7 before the first SCK edge; later bits follow on trailing edges.
REQ-025 CPHA=1: bit 7 SHALL be presented on the first leading edge.
REQ-026 o_SPI_MISO_En SHALL equal o_CS_Active; while CS is inactive, o_SPI_MISO SHALL be 0.
REQ-027 CS deassertion mid-byte:
- The partial RX byte SHALL be discarded, with no o_RX_DV.
- The bit counter SHALL return to 7.
- The TX shift register SHALL be cleared.
- The holding register SHALL be kept.
REQ-028 SCK edges while CS is inactive SHALL have no effect.
REQ-029 Simultaneous i_TX_DV and a byte-boundary transfer: the boundary SHALL consume the old holding content first, then the new byte SHALL load into the holding register.
- If the register was empty, the boundary sends 8'hFF and the new byte is held.
REQ-030 Timing constraint: each SCK half-period SHALL be at least 4 i_Clk cycles; behaviour for faster SCK is undefined.

Reset
REQ-031 While i_Rst=1 at a rising i_Clk, all state SHALL reset:
- o_TX_Ready=1, o_RX_DV=0, o_RX_Byte=8'h00, o_CS_Active=0, o_SPI_MISO=0, o_SPI_MISO_En=0.
- Bit count 7, holding register empty, synchronizers to idle (SCK=CPOL, CS_n=1, MOSI=0).
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no o_RX_DV.
- After release, the block SHALL wait for a fresh CS falling edge before responding.

Verification
REQ-033 Mode 0, i_TX_DV with 8'hA5, then master sends 8'h3C under CS -> master reads 8'hA5; o_RX_Byte=8'h3C with a single o_RX_DV pulse.
REQ-034 Modes 1, 2 and 3, exchange 8'h81/8'h7E -> both directions correct in every mode.
REQ-035 Two back-to-back bytes in one CS frame, second TX byte loaded after the first boundary -> both bytes received, 2 o_RX_DV pulses, bit count wraps.
REQ-036 No TX byte loaded, 1-byte transfer -> master reads 8'hFF; o_TX_Ready stays 1.
REQ-037 CS deasserted after 5 SCK cycles, then a full byte 8'h55 -> no o_RX_DV for the partial byte; next o_RX_Byte=8'h55.
REQ-038 i_Rst pulsed mid-byte -> outputs return to reset values; the next full CS frame operates normally.
